// File: rtl/mips_cpu_dmem_ctrl.sv
// rtl/mips_cpu_dmem_ctrl.sv - MIPS data-memory controller: one Avalon-MM transfer per load/store
// Define MIPS_CPU_DMEM_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses.
module mips_cpu_dmem_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  size,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  offset,
  output logic        err,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t      state;
  logic        shift_q;
  logic        req_any;
  logic        misalign;
  logic [3:0]  be_next;
  logic [31:0] wd_next;
  logic [31:0] rd_aligned;

  assign req_any = req_read | req_write;

`ifdef MIPS_CPU_DMEM_MISALIGN_TRAP_EN
  assign misalign = ((size == 2'b01) && req_addr[0]) ||
                    ((size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign stall = ((state == IDLE) && req_any) || (state == BUS);

  // Store lanes are computed from the live request so they can be registered at capture.
  always_comb begin
    be_next = 4'b1111;
    wd_next = req_wdata;
    case (size)
      2'b00: begin
        be_next = 4'b0001 << req_addr[1:0];
        wd_next = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_next = req_addr[1] ? 4'b1100 : 4'b0011;
        wd_next = {2{req_wdata[15:0]}};
      end
      default: begin
        be_next = 4'b1111;
        wd_next = req_wdata;
      end
    endcase
  end

  assign rd_aligned = shift_q ? (avm_readdata >> {offset, 3'b000}) : avm_readdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      shift_q        <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      rdata          <= 32'd0;
      offset         <= 2'd0;
      avm_address    <= 32'd0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_byteenable <= 4'd0;
      avm_writedata  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            avm_address <= {req_addr[31:2], 2'b00};
            offset      <= req_addr[1:0];
            shift_q     <= ~size[1];
            if (misalign) begin
              // Trapped access skips the bus entirely and reports straight away.
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state          <= BUS;
              avm_write      <= req_write;
              avm_read       <= ~req_write;
              avm_byteenable <= req_write ? be_next : 4'b1111;
              avm_writedata  <= wd_next;
            end
          end
        end
        BUS: begin
          if (!avm_waitrequest) begin
            if (avm_read) rdata <= rd_aligned;
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_dmem_ctrl.sv
// tb/tb_mips_cpu_dmem_ctrl.sv - self-checking bench for mips_cpu_dmem_ctrl
// Honours MIPS_CPU_DMEM_MISALIGN_TRAP_EN when the design is built with it.
module tb_mips_cpu_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_read, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  size;
  logic        stall, done, err;
  logic [31:0] rdata;
  logic [1:0]  offset;
  logic [31:0] avm_address;
  logic        avm_read, avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rdata = 32'd0;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdw;
    int          waits;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;

  vec_t tbl[8];
  vec_t rv;

  mips_cpu_dmem_ctrl dut (
    .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .size(size),
    .stall(stall), .done(done), .rdata(rdata), .offset(offset), .err(err),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: lanes as a contiguous run of n bytes, aligned down to n.
  function automatic int m_bytes(logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_be(logic [1:0] sz, logic [1:0] off);
    int n = m_bytes(sz);
    int base = (int'(off) / n) * n;
    logic [3:0] be = 4'd0;
    for (int i = 0; i < n; i++) be[base + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wd(logic [1:0] sz, logic [31:0] wd);
    int n = m_bytes(sz);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rd(logic [1:0] sz, logic [1:0] off, logic [31:0] rdw);
    return (sz < 2'd2) ? (rdw >> (8 * int'(off))) : rdw;
  endfunction

  function automatic bit m_trap(logic [1:0] sz, logic [1:0] off);
`ifdef MIPS_CPU_DMEM_MISALIGN_TRAP_EN
    return ((sz == 2'd1) && off[0]) || ((sz == 2'd2) && (off != 2'd0));
`else
    return 1'b0;
`endif
  endfunction

  task automatic run(input vec_t v);
    bit trap;
    logic [31:0] want_rd;
    trap = m_trap(v.sz, v.addr[1:0]);
    @(negedge clk);
    chk({v.name, "_idle_done"}, 32'(done), 0);
    chk({v.name, "_idle_cmd"}, 32'({avm_read, avm_write}), 0);
    req_read = v.rd; req_write = v.wr; req_addr = v.addr; req_wdata = v.wd;
    size = v.sz; avm_readdata = v.rdw; avm_waitrequest = 1'b1;
    #1 chk({v.name, "_stall_c0"}, 32'(stall), 1);
    @(negedge clk);
    req_read = 1'b0; req_write = 1'b0;
    if (!trap) begin
      for (int c = 0; c <= v.waits; c++) begin
        if (c > 0) @(negedge clk);
        avm_waitrequest = (c < v.waits);
        #1;
        chk({v.name, "_bus_stall"}, 32'(stall), 1);
        chk({v.name, "_bus_done"}, 32'(done), 0);
        chk({v.name, "_bus_read"}, 32'(avm_read), 32'(v.rd && !v.wr));
        chk({v.name, "_bus_write"}, 32'(avm_write), 32'(v.wr));
        chk({v.name, "_bus_addr"}, avm_address, {v.addr[31:2], 2'b00});
        chk({v.name, "_bus_be"}, 32'(avm_byteenable), 32'(v.exp_be));
        if (v.wr) chk({v.name, "_bus_wdata"}, avm_writedata, v.exp_wd);
      end
      @(negedge clk);
    end
    want_rd = (v.wr || trap) ? last_rdata : v.exp_rd;
    chk({v.name, "_done"}, 32'(done), 1);
    chk({v.name, "_done_stall"}, 32'(stall), 0);
    chk({v.name, "_err"}, 32'(err), 32'(trap));
    chk({v.name, "_done_cmd"}, 32'({avm_read, avm_write}), 0);
    chk({v.name, "_offset"}, 32'(offset), 32'(v.addr[1:0]));
    chk({v.name, "_rdata"}, rdata, want_rd);
    last_rdata = want_rd;
    avm_waitrequest = 1'b0;
  endtask

  task automatic fill_model(inout vec_t v);
    v.exp_be = v.wr ? m_be(v.sz, v.addr[1:0]) : 4'hF;
    v.exp_wd = m_wd(v.sz, v.wd);
    v.exp_rd = m_rd(v.sz, v.addr[1:0], v.rdw);
  endtask

  initial begin
    tbl[0] = '{0, 1, 2'd2, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 4'hF, 32'h0, 32'hDEAD_BEEF, "lw1004"};
    tbl[1] = '{0, 1, 2'd0, 32'h0000_2003, 32'h0, 32'hAB12_3456, 3, 4'hF, 32'h0, 32'h0000_00AB, "lb2003"};
    tbl[2] = '{1, 0, 2'd1, 32'h0000_3002, 32'h0000_CAFE, 32'h0, 0, 4'b1100, 32'hCAFE_CAFE, 32'h0, "sh3002"};
    tbl[3] = '{1, 1, 2'd0, 32'h0000_5001, 32'h0000_0055, 32'h0, 1, 4'b0010, 32'h5555_5555, 32'h0, "sb_rw"};
    tbl[4] = '{0, 1, 2'd1, 32'h0000_6002, 32'h0, 32'h1234_ABCD, 1, 4'hF, 32'h0, 32'h0000_1234, "lh6002"};
    tbl[5] = '{1, 0, 2'd2, 32'h0000_7000, 32'h0102_0304, 32'h0, 2, 4'hF, 32'h0102_0304, 32'h0, "sw7000"};
    tbl[6] = '{0, 1, 2'd3, 32'h0000_8003, 32'h0, 32'hCAFE_F00D, 0, 4'hF, 32'h0, 32'hCAFE_F00D, "lwl8003"};
    tbl[7] = '{1, 0, 2'd0, 32'h0000_9000, 32'h0000_00E7, 32'h0, 0, 4'b0001, 32'hE7E7_E7E7, 32'h0, "sb9000"};

    reset = 1'b1; req_read = 1'b0; req_write = 1'b0; req_addr = 32'd0;
    req_wdata = 32'd0; size = 2'd0; avm_readdata = 32'd0; avm_waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'({stall, done, err, avm_read, avm_write}), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_offset", 32'(offset), 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_wdata", avm_writedata, 0);
    chk("rst_be", 32'(avm_byteenable), 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run(tbl[i]);

    // Misaligned word (trapped only when the trap option is built in), then lwl at same address.
    rv = '{0, 1, 2'd2, 32'h0000_4002, 32'h0, 32'h7654_3210, 0, 4'hF, 32'h0, 32'h0, "lw4002"};
    fill_model(rv);
    run(rv);
    rv = '{0, 1, 2'd3, 32'h0000_4002, 32'h0, 32'h0BAD_F00D, 0, 4'hF, 32'h0, 32'h0, "lwl4002"};
    fill_model(rv);
    run(rv);

    // Reset while the bus is stalled: transfer is abandoned, outputs return to reset values.
    @(negedge clk);
    req_read = 1'b1; req_addr = 32'h0000_A008; size = 2'd2; avm_waitrequest = 1'b1;
    @(negedge clk);
    req_read = 1'b0;
    chk("rstbus_read_before", 32'(avm_read), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rstbus_read", 32'(avm_read), 0);
    chk("rstbus_stall", 32'(stall), 0);
    chk("rstbus_rdata", rdata, 0);
    chk("rstbus_outs", 32'({done, err, offset, avm_byteenable}), 0);
    chk("rstbus_addr", avm_address, 0);
    reset = 1'b0; avm_waitrequest = 1'b0; last_rdata = 32'd0;
    @(negedge clk);
    chk("rstbus_no_retry", 32'({avm_read, avm_write, stall}), 0);

    for (int i = 0; i < 40; i++) begin
      rv.wr = 1'($urandom_range(0, 1));
      rv.rd = rv.wr ? 1'($urandom_range(0, 1)) : 1'b1;
      rv.sz = 2'($urandom_range(0, 3));
      rv.addr = $urandom;
      rv.wd = $urandom;
      rv.rdw = $urandom;
      rv.waits = $urandom_range(0, 3);
      rv.name = "rand";
      fill_model(rv);
      run(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
